// File: rtl/ssd_scan_driver_if.sv
// Bus bundle between a display controller (master) and the multiplexed
// seven-segment scan driver (slave): display contents in, pin drives out.
interface ssd_scan_driver_if #(
   parameter int NUM_DIGITS = 8,
   parameter int PWM_BITS   = 4
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    lz_blank;
   logic [PWM_BITS-1:0]     brightness;
   logic                    load;
   logic [NUM_DIGITS-1:0]   An;
   logic [7:0]              Cathodes;
   logic                    frame_done;

   modport master (
      output digits_in, dp_in, digit_en, lz_blank, brightness, load,
      input  An, Cathodes, frame_done
   );

   modport slave (
      input  digits_in, dp_in, digit_en, lz_blank, brightness, load,
      output An, Cathodes, frame_done
   );
endinterface

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with leading-zero suppression, anti-ghost
// blank gap, PWM brightness and frame-synchronous double-buffered loading.
module ssd_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 262144,
   parameter int BLANK_CYCLES = 1024,
   parameter int PWM_BITS     = 4,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic             ClkPort,
   input  logic             Reset,
   ssd_scan_driver_if.slave bus
);
   localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
   localparam logic [SLOT_W-1:0]     BLANK_END = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_IDLE   = ACTIVE_LOW ? '1 : '0;
   localparam logic [7:0]            CATH_IDLE = ACTIVE_LOW ? 8'hFF : 8'h00;

   typedef enum logic {SLOT_BLANK, SLOT_ON} slot_state_e;

   logic [SLOT_W-1:0]           slot_cnt;
   logic [IDX_W-1:0]            dig_idx;
   logic [PWM_BITS-1:0]         pwm_cnt;
   logic                        load_pending;
   logic [NUM_DIGITS-1:0][3:0]  digits_sh;
   logic [NUM_DIGITS-1:0]       dp_sh;
   logic [NUM_DIGITS-1:0]       en_sh;
   logic                        lz_sh;
   logic [PWM_BITS-1:0]         bright_sh;

   slot_state_e                 slot_state;
   logic                        frame_wrap;
   logic                        pwm_on;
   logic                        digit_lit;
   logic                        upper_zero;
   logic [NUM_DIGITS-1:0]       lz_mask;
   logic [NUM_DIGITS-1:0]       an_act;
   logic [7:0]                  cath_low;

   // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
   function automatic logic [6:0] seg_low(input logic [3:0] nib);
      case (nib)
         4'h0:    seg_low = 7'b0000001;
         4'h1:    seg_low = 7'b1001111;
         4'h2:    seg_low = 7'b0010010;
         4'h3:    seg_low = 7'b0000110;
         4'h4:    seg_low = 7'b1001100;
         4'h5:    seg_low = 7'b0100100;
         4'h6:    seg_low = 7'b0100000;
         4'h7:    seg_low = 7'b0001111;
         4'h8:    seg_low = 7'b0000000;
         4'h9:    seg_low = 7'b0000100;
         4'hA:    seg_low = 7'b0001000;
         4'hB:    seg_low = 7'b1100000;
         4'hC:    seg_low = 7'b0110001;
         4'hD:    seg_low = 7'b1000010;
         4'hE:    seg_low = 7'b0110000;
         default: seg_low = 7'b0111000;
      endcase
   endfunction

   // A digit is blanked when it and every more-significant nibble are zero; digit 0 always shows.
   always_comb begin
      upper_zero = 1'b1;
      lz_mask    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (digits_sh[i] == 4'd0);
         lz_mask[i] = lz_sh & (i != 0) & upper_zero;
      end
   end

   // Cathodes are gated with the anode so a dark digit never drives segments.
   always_comb begin
      slot_state = (slot_cnt < BLANK_END) ? SLOT_BLANK : SLOT_ON;
      frame_wrap = (slot_cnt == SLOT_LAST) && (dig_idx == IDX_LAST);
      pwm_on     = (bright_sh == '1) || (pwm_cnt < bright_sh);
      digit_lit  = (slot_state == SLOT_ON) && en_sh[dig_idx] && !lz_mask[dig_idx] && pwm_on;
      an_act     = digit_lit ? (NUM_DIGITS'(1) << dig_idx) : '0;
      cath_low   = digit_lit ? {seg_low(digits_sh[dig_idx]), ~dp_sh[dig_idx]} : 8'hFF;
   end

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         slot_cnt <= '0;
         dig_idx  <= '0;
         pwm_cnt  <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

   // A load seen at the wrap edge itself is honoured there, so pending clears unconditionally.
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         load_pending <= 1'b0;
         digits_sh    <= '0;
         dp_sh        <= '0;
         en_sh        <= '0;
         lz_sh        <= 1'b0;
         bright_sh    <= '0;
      end else if (frame_wrap) begin
         load_pending <= 1'b0;
         if (load_pending || bus.load) begin
            digits_sh <= bus.digits_in;
            dp_sh     <= bus.dp_in;
            en_sh     <= bus.digit_en;
            lz_sh     <= bus.lz_blank;
            bright_sh <= bus.brightness;
         end
      end else if (bus.load) begin
         load_pending <= 1'b1;
      end
   end

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         bus.An         <= AN_IDLE;
         bus.Cathodes   <= CATH_IDLE;
         bus.frame_done <= 1'b0;
      end else begin
         bus.An         <= ACTIVE_LOW ? ~an_act : an_act;
         bus.Cathodes   <= ACTIVE_LOW ? cath_low : ~cath_low;
         bus.frame_done <= frame_wrap;
      end
   end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: hand-computed vector table, corner
// sequences, and randomized traffic checked against a frame-arithmetic model.
module tb_ssd_scan_driver;
   localparam int ND    = 4;
   localparam int DC    = 16;
   localparam int BC    = 4;
   localparam int PB    = 2;
   localparam int FRAME = ND * DC;

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic        lz;
      logic [1:0]  bright;
   } cfg_t;

   typedef struct packed {
      cfg_t            cfg;
      logic [3:0][3:0] an;
      logic [3:0][7:0] cath;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ssd_scan_driver_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus ();

   ssd_scan_driver #(
      .NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .PWM_BITS(PB), .ACTIVE_LOW(1'b1)
   ) dut (
      .ClkPort(clk),
      .Reset(rst),
      .bus(bus)
   );

   int         tests_run = 0;
   int         tests_failed = 0;
   int         k;
   cfg_t       sh;
   cfg_t       cur;
   bit         pend;
   logic       load_v;
   int         obs_dig;
   int         obs_slot;
   logic [6:0] seg_tab [16];
   vec_t       vecs [6];

   // Model: after k edges since reset release the scan sits at digit (k%FRAME)/DC, slot k%DC.
   function automatic bit m_lit(input int kk, input cfg_t s);
      int d   = (kk % FRAME) / DC;
      int p   = kk % (1 << PB);
      bit pwm = (s.bright == 2'd3) || (p < int'(s.bright));
      bit lzb = s.lz && (d != 0) && ((s.digits >> (4 * d)) == 16'd0);
      if ((kk % DC) < BC) return 1'b0;
      return s.en[d] && !lzb && pwm;
   endfunction

   function automatic logic [3:0] m_an(input int kk, input cfg_t s);
      logic [3:0] one_hot = 4'b0001 << ((kk % FRAME) / DC);
      return m_lit(kk, s) ? ~one_hot : 4'hF;
   endfunction

   function automatic logic [7:0] m_cath(input int kk, input cfg_t s);
      int         d   = (kk % FRAME) / DC;
      logic [3:0] nib = 4'((s.digits >> (4 * d)) & 16'hF);
      return m_lit(kk, s) ? {seg_tab[nib], ~s.dp[d]} : 8'hFF;
   endfunction

   function automatic vec_t mk(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] en,
                               input logic lz, input logic [1:0] br,
                               input logic [15:0] an, input logic [31:0] cath);
      vec_t v;
      v.cfg.digits = dg;
      v.cfg.dp     = dp;
      v.cfg.en     = en;
      v.cfg.lz     = lz;
      v.cfg.bright = br;
      v.an         = an;
      v.cath       = cath;
      return v;
   endfunction

   function automatic cfg_t rand_cfg();
      cfg_t c;
      c.digits = 16'($urandom) >> (4 * $urandom_range(0, 4));
      c.dp     = 4'($urandom);
      c.en     = 4'($urandom) | 4'($urandom);
      c.lz     = 1'($urandom);
      c.bright = 2'($urandom);
      return c;
   endfunction

   task automatic applyStimulus(input cfg_t c, input logic ld);
      cur            = c;
      load_v         = ld;
      bus.digits_in  = c.digits;
      bus.dp_in      = c.dp;
      bus.digit_en   = c.en;
      bus.lz_blank   = c.lz;
      bus.brightness = c.bright;
      bus.load       = ld;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s at model cycle %0d: got %h, expected %h", name, k, act, exp);
      end
   endtask

   // One clock: predict the registered outputs from the pre-edge state, then apply the shadow rule.
   task automatic step();
      logic [3:0] e_an;
      logic [7:0] e_cath;
      bit         wrap;
      @(posedge clk);
      e_an     = m_an(k, sh);
      e_cath   = m_cath(k, sh);
      obs_dig  = (k % FRAME) / DC;
      obs_slot = k % DC;
      wrap     = ((k + 1) % FRAME) == 0;
      if (wrap) begin
         if (pend || load_v) sh = cur;
         pend = 1'b0;
      end else if (load_v) begin
         pend = 1'b1;
      end
      k = k + 1;
      #1;
      checkOutput("an", {4'h0, bus.An}, {4'h0, e_an});
      checkOutput("cathodes", bus.Cathodes, e_cath);
      checkOutput("frame_done", {7'd0, bus.frame_done}, {7'd0, wrap});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic to_frame_start();
      int guard = 0;
      while ((k % FRAME) != 0 && guard < FRAME) begin
         step();
         guard++;
      end
   endtask

   task automatic load_cfg(input cfg_t c);
      applyStimulus(c, 1'b1);
      step();
      applyStimulus(c, 1'b0);
      to_frame_start();
   endtask

   task automatic run_check(input int n, input int dig, input logic [7:0] exp, input string name);
      for (int i = 0; i < n; i++) begin
         step();
         if (obs_dig == dig && obs_slot == 8) checkOutput(name, bus.Cathodes, exp);
      end
   endtask

   task automatic model_reset();
      k    = 0;
      sh   = '0;
      pend = 1'b0;
   endtask

   initial begin
      int   fd_cnt;
      int   lit_cnt [ND];
      cfg_t c;

      seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
      seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
      seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
      seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
      seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000;
      seg_tab[15] = 7'b0111000;

      // Expected An / Cathodes per digit while lit, packed {digit3, digit2, digit1, digit0}.
      vecs[0] = mk(16'h1234, 4'b0001, 4'hF, 1'b0, 2'd3, 16'h7BDE, 32'h9F250D98);
      vecs[1] = mk(16'h0070, 4'b0000, 4'hF, 1'b1, 2'd3, 16'hFFDE, 32'hFFFF1F03);
      vecs[2] = mk(16'h0000, 4'b0000, 4'hF, 1'b1, 2'd3, 16'hFFFE, 32'hFFFFFF03);
      vecs[3] = mk(16'hF0E8, 4'b1010, 4'b0111, 1'b0, 2'd3, 16'hFBDE, 32'hFF036001);
      vecs[4] = mk(16'h5A9C, 4'b0100, 4'hF, 1'b1, 2'd3, 16'h7BDE, 32'h49100963);
      vecs[5] = mk(16'h00B6, 4'b0000, 4'hF, 1'b0, 2'd3, 16'h7BDE, 32'h0303C141);

      applyStimulus('0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_an", {4'h0, bus.An}, 8'h0F);
      checkOutput("reset_cathodes", bus.Cathodes, 8'hFF);
      checkOutput("reset_frame_done", {7'd0, bus.frame_done}, 8'h00);
      rst = 1'b0;
      model_reset();

      // No load after reset: dark display, frame_done every FRAME cycles.
      fd_cnt = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         step();
         if (bus.frame_done) fd_cnt++;
      end
      checkOutput("idle_frame_count", 8'(fd_cnt), 8'd3);

      for (int v = 0; v < 6; v++) begin
         load_cfg(vecs[v].cfg);
         for (int d = 0; d < ND; d++) lit_cnt[d] = 0;
         for (int i = 0; i < FRAME; i++) begin
            step();
            if (bus.An != 4'hF) lit_cnt[obs_dig]++;
            if (obs_slot == 8) begin
               checkOutput("vec_an", {4'h0, bus.An}, {4'h0, vecs[v].an[obs_dig]});
               checkOutput("vec_cathodes", bus.Cathodes, vecs[v].cath[obs_dig]);
            end
         end
         for (int d = 0; d < ND; d++)
            checkOutput("vec_lit_cycles", 8'(lit_cnt[d]), (vecs[v].an[d] != 4'hF) ? 8'd12 : 8'd0);
      end

      // PWM: brightness 1 lights one cycle in four of each ON window, brightness 0 none.
      c = vecs[0].cfg;
      c.dp = 4'b0000;
      c.bright = 2'd1;
      load_cfg(c);
      for (int d = 0; d < ND; d++) lit_cnt[d] = 0;
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (bus.An[obs_dig] == 1'b0) lit_cnt[obs_dig]++;
      end
      for (int d = 0; d < ND; d++) checkOutput("pwm_quarter", 8'(lit_cnt[d]), 8'd3);
      c.bright = 2'd0;
      load_cfg(c);
      fd_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (bus.An != 4'hF) fd_cnt++;
      end
      checkOutput("pwm_dark", 8'(fd_cnt), 8'd0);

      // Mid-frame load waits for the boundary; a load on the boundary edge applies there.
      load_cfg(vecs[0].cfg);
      run(20);
      applyStimulus(vecs[4].cfg, 1'b1);
      step();
      applyStimulus(vecs[4].cfg, 1'b0);
      run_check(FRAME - 21, 2, 8'h25, "late_load_old");
      run_check(FRAME - 1, 2, 8'h10, "late_load_new");
      applyStimulus(vecs[5].cfg, 1'b1);
      step();
      applyStimulus(vecs[5].cfg, 1'b0);
      run_check(FRAME, 0, 8'h41, "boundary_load");

      // Randomized inputs: free changes while nothing is pending, held stable after a load.
      for (int f = 0; f < 12; f++) begin
         bit held;
         bit do_load;
         int r;
         held    = 1'b0;
         do_load = 1'($urandom);
         r       = int'($urandom_range(0, FRAME - 1));
         to_frame_start();
         for (int i = 0; i < FRAME; i++) begin
            if (!held && $urandom_range(0, 2) == 0) applyStimulus(rand_cfg(), 1'b0);
            if (do_load && i == r) begin
               applyStimulus(cur, 1'b1);
               held = 1'b1;
            end
            step();
            if (load_v) applyStimulus(cur, 1'b0);
         end
      end

      // Asynchronous reset mid-slot of digit 2 must darken the display without a clock edge.
      to_frame_start();
      load_cfg(vecs[0].cfg);
      run(2 * DC + 9);
      rst = 1'b1;
      #1;
      checkOutput("async_reset_an", {4'h0, bus.An}, 8'h0F);
      checkOutput("async_reset_cathodes", bus.Cathodes, 8'hFF);
      checkOutput("async_reset_frame_done", {7'd0, bus.frame_done}, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("held_reset_an", {4'h0, bus.An}, 8'h0F);
      rst = 1'b0;
      model_reset();
      fd_cnt = 0;
      for (int i = 0; i < FRAME + 8; i++) begin
         step();
         if (bus.An != 4'hF) fd_cnt++;
      end
      checkOutput("post_reset_dark", 8'(fd_cnt), 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
